// File: rtl/uart_apb_arbiter.sv
// Round-robin APB arbiter that shares the UART APB completer among NrReq requesters.
// Define UART_APB_ARB_TIMEOUT_EN to add the ACCESS-phase watchdog.

module uart_apb_arbiter_chk #(
    parameter int unsigned NrReq         = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NrReq-1:0] req_psel_i,
    input  logic [NrReq-1:0] req_penable_i,
    input  logic [NrReq-1:0] req_pready_o
);

    tmo_range: assert property (@(posedge clk_i) (TimeoutCycles >= 32'd1) && (TimeoutCycles <= 32'd65535));

    penable_needs_psel: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_penable_i & ~req_psel_i) == {NrReq{1'b0}});

    pready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_pready_o));

endmodule

module uart_apb_arbiter #(
    parameter int unsigned NrReq         = 2,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NrReq-1:0]                req_psel_i,
    input  logic [NrReq-1:0]                req_penable_i,
    input  logic [NrReq-1:0]                req_pwrite_i,
    input  logic [NrReq-1:0][AddrWidth-1:0] req_paddr_i,
    input  logic [NrReq-1:0][DataWidth-1:0] req_pwdata_i,
    output logic [NrReq-1:0][DataWidth-1:0] req_prdata_o,
    output logic [NrReq-1:0]                req_pready_o,
    output logic [NrReq-1:0]                req_pslverr_o,
    output logic                            uart_psel_o,
    output logic                            uart_penable_o,
    output logic                            uart_pwrite_o,
    output logic [AddrWidth-1:0]            uart_paddr_o,
    output logic [DataWidth-1:0]            uart_pwdata_o,
    input  logic [DataWidth-1:0]            uart_prdata_i,
    input  logic                            uart_pready_i,
    input  logic                            uart_pslverr_i
);

    localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
    typedef logic [IdxW-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_e;

    state_e                 state_r;
    state_e                 state_s;
    idx_t                   grant_r;
    idx_t                   rr_ptr_r;
    idx_t                   pick_s;
    idx_t                   cand_idx_s;
    idx_t                   rr_next_s;
    int unsigned            cand_s;
    logic                   any_req_s;
    logic                   done_s;
    logic                   timeout_s;
    logic                   pwrite_r;
    logic [AddrWidth-1:0]   paddr_r;
    logic [DataWidth-1:0]   pwdata_r;

    // Round-robin search: first PSEL at or above rr_ptr_r, wrapping to index 0.
    always_comb begin
        pick_s     = rr_ptr_r;
        any_req_s  = 1'b0;
        cand_s     = 32'd0;
        cand_idx_s = rr_ptr_r;
        for (int unsigned i = 0; i < NrReq; i++) begin
            cand_s = 32'(rr_ptr_r) + i;
            if (cand_s >= NrReq) begin
                cand_s = cand_s - NrReq;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = idx_t'(cand_s);
            if (!any_req_s && req_psel_i[cand_idx_s]) begin
                any_req_s = 1'b1;
                pick_s    = cand_idx_s;
            end else begin
                any_req_s = any_req_s;
            end
        end
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        if (grant_r == idx_t'(NrReq - 1)) begin
            rr_next_s = {IdxW{1'b0}};
        end else begin
            rr_next_s = grant_r + idx_t'(1);
        end
    end

`ifdef UART_APB_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;

    // Watchdog counter: cleared on SETUP entry, counts unanswered ACCESS cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_ACCESS) && !uart_pready_i) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // The count includes the current cycle, so the limit hits on the TimeoutCycles-th ACCESS cycle.
    assign timeout_s = (state_r == ST_ACCESS) && !uart_pready_i &&
                       (tmo_cnt_r == 16'(TimeoutCycles - 32'd1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic for the IDLE/SETUP/ACCESS sequencer.
    always_comb begin
        state_s = state_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (uart_pready_i || timeout_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, pointer and latched transfer fields; fields are frozen from SETUP through ACCESS.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_r  <= {IdxW{1'b0}};
            rr_ptr_r <= {IdxW{1'b0}};
            pwrite_r <= 1'b0;
            paddr_r  <= {AddrWidth{1'b0}};
            pwdata_r <= {DataWidth{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && any_req_s) begin
                grant_r  <= pick_s;
                pwrite_r <= req_pwrite_i[pick_s];
                paddr_r  <= req_paddr_i[pick_s];
                pwdata_r <= req_pwdata_i[pick_s];
            end
            if (done_s) begin
                rr_ptr_r <= rr_next_s;
            end
        end
    end

    // Response routing; a requester that already dropped PSEL never sees its response.
    always_comb begin
        req_pready_o  = {NrReq{1'b0}};
        req_pslverr_o = {NrReq{1'b0}};
        req_prdata_o  = {(NrReq * DataWidth){1'b0}};
        if (done_s && req_psel_i[grant_r]) begin
            req_pready_o[grant_r] = 1'b1;
            if (uart_pready_i) begin
                req_pslverr_o[grant_r] = uart_pslverr_i;
                req_prdata_o[grant_r]  = uart_prdata_i;
            end else begin
                req_pslverr_o[grant_r] = 1'b1;
            end
        end else begin
            req_pready_o = {NrReq{1'b0}};
        end
    end

    assign uart_psel_o    = (state_r != ST_IDLE);
    assign uart_penable_o = (state_r == ST_ACCESS);
    assign uart_pwrite_o  = pwrite_r;
    assign uart_paddr_o   = paddr_r;
    assign uart_pwdata_o  = pwdata_r;

    uart_apb_arbiter_chk #(
        .NrReq         (NrReq),
        .TimeoutCycles (TimeoutCycles)
    ) u_chk (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_psel_i    (req_psel_i),
        .req_penable_i (req_penable_i),
        .req_pready_o  (req_pready_o)
    );

endmodule
